// File: rtl/dadd_arb.sv
// Round-robin arbiter sharing one dadd increment datapath between NREQ requesters.
// Results are routed back to the issuing channel through a two-stage tag pipe.
module dadd_arb #(
    parameter int NREQ   = 4,
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arb_en,
    output logic                   arb_idle,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    input  logic [NREQ*AWIDTH-1:0] req_addr,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DWIDTH-1:0]      rsp_data,
    output logic [AWIDTH-1:0]      rsp_addr,
    output logic                   dadd_in_en,
    output logic [DWIDTH-1:0]      dadd_in,
    output logic [AWIDTH-1:0]      dadd_in_addr,
    input  logic                   dadd_out_en,
    input  logic [DWIDTH-1:0]      dadd_out,
    input  logic [AWIDTH-1:0]      dadd_out_addr,
    output logic [15:0]            issue_cnt
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                tag1_valid_q, tag1_valid_d;
    logic [PW-1:0]       tag1_id_q, tag1_id_d;
    logic                tag2_valid_q, tag2_valid_d;
    logic [PW-1:0]       tag2_id_q, tag2_id_d;
    logic                dadd_in_en_q, dadd_in_en_d;
    logic [DWIDTH-1:0]   dadd_in_q, dadd_in_d;
    logic [AWIDTH-1:0]   dadd_in_addr_q, dadd_in_addr_d;
    logic [15:0]         issue_cnt_q, issue_cnt_d;
    logic                arb_idle_q, arb_idle_d;

    logic                grant_found;
    logic                grant;
    logic [PW-1:0]       winner;
    logic [PW-1:0]       scan_idx;
    logic [DWIDTH-1:0]   win_data;
    logic [AWIDTH-1:0]   win_addr;

    // Rotating priority scan starting at rr_ptr; first valid channel wins.
    always_comb begin
        grant_found = 1'b0;
        winner      = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                winner      = scan_idx;
            end
        end
    end

    assign grant = (state_q == RUN) && arb_en && grant_found;

    always_comb begin
        win_data  = '0;
        win_addr  = '0;
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == PW'(i)) begin
                win_data = req_data[i*DWIDTH +: DWIDTH];
                win_addr = req_addr[i*AWIDTH +: AWIDTH];
            end
            if (tag2_id_q == PW'(i)) begin
                rsp_valid[i] = dadd_out_en & tag2_valid_q;
            end
        end
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    // The op held in tag2 returns this cycle, so only tag1 can keep DRAIN busy.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        tag1_valid_d   = grant;
        tag1_id_d      = winner;
        tag2_valid_d   = tag1_valid_q;
        tag2_id_d      = tag1_id_q;
        dadd_in_en_d   = grant;
        dadd_in_d      = dadd_in_q;
        dadd_in_addr_d = dadd_in_addr_q;
        issue_cnt_d    = issue_cnt_q;
        case (state_q)
            IDLE:    if (arb_en) state_d = RUN;
            RUN:     if (!arb_en) state_d = DRAIN;
            DRAIN:   if (!tag1_valid_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (grant) begin
            rr_ptr_d       = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
            dadd_in_d      = win_data;
            dadd_in_addr_d = win_addr;
            issue_cnt_d    = issue_cnt_q + 16'd1;
        end
        arb_idle_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            tag1_valid_q   <= 1'b0;
            tag1_id_q      <= '0;
            tag2_valid_q   <= 1'b0;
            tag2_id_q      <= '0;
            dadd_in_en_q   <= 1'b0;
            dadd_in_q      <= '0;
            dadd_in_addr_q <= '0;
            issue_cnt_q    <= '0;
            arb_idle_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            tag1_valid_q   <= tag1_valid_d;
            tag1_id_q      <= tag1_id_d;
            tag2_valid_q   <= tag2_valid_d;
            tag2_id_q      <= tag2_id_d;
            dadd_in_en_q   <= dadd_in_en_d;
            dadd_in_q      <= dadd_in_d;
            dadd_in_addr_q <= dadd_in_addr_d;
            issue_cnt_q    <= issue_cnt_d;
            arb_idle_q     <= arb_idle_d;
        end
    end

    assign arb_idle     = arb_idle_q;
    assign dadd_in_en   = dadd_in_en_q;
    assign dadd_in      = dadd_in_q;
    assign dadd_in_addr = dadd_in_addr_q;
    assign issue_cnt    = issue_cnt_q;
    assign rsp_data     = dadd_out;
    assign rsp_addr     = dadd_out_addr;

endmodule

// File: tb/tb_dadd_arb.sv
// Directed bench for dadd_arb with a one-cycle dadd increment model.
// Cycle table covers arbitration, responses, drain and reset; hand sequences cover wrap.
module tb_dadd_arb;

    localparam int NREQ = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                arb_en = 1'b0;
    logic                arb_idle;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*32-1:0]  req_data;
    logic [NREQ*32-1:0]  req_addr;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_data;
    logic [31:0]         rsp_addr;
    logic                dadd_in_en;
    logic [31:0]         dadd_in;
    logic [31:0]         dadd_in_addr;
    logic                dadd_out_en = 1'b0;
    logic [31:0]         dadd_out = '0;
    logic [31:0]         dadd_out_addr = '0;
    logic [15:0]         issue_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] ch_data [NREQ] = '{32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0040};
    logic [31:0] ch_addr [NREQ] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400};

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  valid;
        logic [3:0]  ready;
        logic [3:0]  rsp;
        logic        din_en;
        logic        idle;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [36];

    dadd_arb #(.NREQ(NREQ), .AWIDTH(32), .DWIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .arb_en        (arb_en),
        .arb_idle      (arb_idle),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_addr      (rsp_addr),
        .dadd_in_en    (dadd_in_en),
        .dadd_in       (dadd_in),
        .dadd_in_addr  (dadd_in_addr),
        .dadd_out_en   (dadd_out_en),
        .dadd_out      (dadd_out),
        .dadd_out_addr (dadd_out_addr),
        .issue_cnt     (issue_cnt)
    );

    always #5 clk = ~clk;

    // dadd stand-in: one-cycle increment, deliberately not reset so stale strobes reach the arbiter.
    always @(posedge clk) begin
        dadd_out_en   <= dadd_in_en;
        dadd_out      <= dadd_in + 32'd1;
        dadd_out_addr <= dadd_in_addr;
    end

    function automatic vec_t mk(input logic r, input logic e, input logic [3:0] v,
                                input logic [3:0] rdy, input logic [3:0] rsp,
                                input logic din, input logic idl, input logic [15:0] c);
        vec_t t;
        t.rst = r; t.en = e; t.valid = v; t.ready = rdy; t.rsp = rsp;
        t.din_en = din; t.idle = idl; t.cnt = c;
        return t;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic e, input logic [3:0] v);
        @(negedge clk);
        rst       = r;
        arb_en    = e;
        req_valid = v;
        #1;
    endtask

    initial begin
        int bad;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*32 +: 32] = ch_data[i];
            req_addr[i*32 +: 32] = ch_addr[i];
        end

        //          rst   en    valid    ready    rsp      din   idle  cnt
        vecs[0]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'd0);
        vecs[1]  = mk(1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 16'd0);
        vecs[2]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'd1);
        vecs[3]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 16'd1);
        vecs[4]  = mk(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd1);
        vecs[5]  = mk(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'd0);
        vecs[6]  = mk(1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b0, 16'd0);
        vecs[7]  = mk(1'b0, 1'b1, 4'b1111, 4'b0010, 4'b0000, 1'b1, 1'b0, 16'd1);
        vecs[8]  = mk(1'b0, 1'b1, 4'b1111, 4'b0100, 4'b0001, 1'b1, 1'b0, 16'd2);
        vecs[9]  = mk(1'b0, 1'b1, 4'b1111, 4'b1000, 4'b0010, 1'b1, 1'b0, 16'd3);
        vecs[10] = mk(1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0100, 1'b1, 1'b0, 16'd4);
        vecs[11] = mk(1'b0, 1'b1, 4'b1111, 4'b0010, 4'b1000, 1'b1, 1'b0, 16'd5);
        vecs[12] = mk(1'b0, 1'b1, 4'b1111, 4'b0100, 4'b0001, 1'b1, 1'b0, 16'd6);
        vecs[13] = mk(1'b0, 1'b1, 4'b1111, 4'b1000, 4'b0010, 1'b1, 1'b0, 16'd7);
        vecs[14] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 16'd8);
        vecs[15] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, 16'd8);
        vecs[16] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd8);
        vecs[17] = mk(1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 16'd8);
        vecs[18] = mk(1'b0, 1'b1, 4'b1010, 4'b1000, 4'b0000, 1'b1, 1'b0, 16'd9);
        vecs[19] = mk(1'b0, 1'b1, 4'b1010, 4'b0010, 4'b0010, 1'b1, 1'b0, 16'd10);
        vecs[20] = mk(1'b0, 1'b1, 4'b1010, 4'b1000, 4'b1000, 1'b1, 1'b0, 16'd11);
        vecs[21] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 16'd12);
        vecs[22] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, 16'd12);
        vecs[23] = mk(1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 16'd12);
        vecs[24] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'd13);
        vecs[25] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 16'd13);
        vecs[26] = mk(1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 16'd13);
        vecs[27] = mk(1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'd14);
        vecs[28] = mk(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 16'd14);
        vecs[29] = mk(1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'd14);
        vecs[30] = mk(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'd14);
        vecs[31] = mk(1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 16'd14);
        vecs[32] = mk(1'b0, 1'b1, 4'b0011, 4'b0010, 4'b0000, 1'b1, 1'b0, 16'd15);
        vecs[33] = mk(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 16'd16);
        vecs[34] = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'd0);
        vecs[35] = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_output("reset req_ready", 32'(req_ready), 32'h0);
        check_output("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check_output("reset arb_idle", 32'(arb_idle), 32'h1);
        check_output("reset dadd_in_en", 32'(dadd_in_en), 32'h0);
        check_output("reset dadd_in", dadd_in, 32'h0);
        check_output("reset issue_cnt", 32'(issue_cnt), 32'h0);

        for (int i = 0; i < 36; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].en, vecs[i].valid);
            check_output($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].ready));
            check_output($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rsp));
            check_output($sformatf("v%0d dadd_in_en", i), 32'(dadd_in_en), 32'(vecs[i].din_en));
            check_output($sformatf("v%0d arb_idle", i), 32'(arb_idle), 32'(vecs[i].idle));
            check_output($sformatf("v%0d issue_cnt", i), 32'(issue_cnt), 32'(vecs[i].cnt));
            for (int j = 0; j < NREQ; j++) begin
                if (vecs[i].rsp[j]) begin
                    check_output($sformatf("v%0d rsp_data", i), rsp_data, ch_data[j] + 32'd1);
                    check_output($sformatf("v%0d rsp_addr", i), rsp_addr, ch_addr[j]);
                end
            end
        end

        // Reset after grants must have cleared the issue registers.
        check_output("post-reset dadd_in", dadd_in, 32'h0);
        check_output("post-reset dadd_in_addr", dadd_in_addr, 32'h0);

        // Lone requester: granted every cycle, counter wraps 0xFFFF -> 0.
        apply_stimulus(1'b0, 1'b1, 4'b0001);
        bad = 0;
        for (int k = 0; k < 65536; k++) begin
            apply_stimulus(1'b0, 1'b1, 4'b0001);
            if (req_ready !== 4'b0001) bad++;
            if (k == 65535) check_output("issue_cnt at 0xFFFF", 32'(issue_cnt), 32'h0000_FFFF);
        end
        apply_stimulus(1'b0, 1'b1, 4'b0000);
        check_output("issue_cnt wrap", 32'(issue_cnt), 32'h0);
        check_output("lone requester grants missed", 32'(bad), 32'h0);
        check_output("lone dadd_in", dadd_in, ch_data[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
